// File: rtl/mem_pkg.sv
// Shared types and defaults for the byte-serial load/store master.
package mem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_e;

  localparam int ADDR_W_DEF      = 7;
  localparam int BYTES_PER_WORD  = 4;
  localparam int ACK_TIMEOUT_DEF = 15;
endpackage

// File: rtl/lsu_byte_master_if.sv
// Pipeline request/response and byte-wide memory bus of the LSU.
interface lsu_byte_master_if #(parameter int ADDR_W = mem_pkg::ADDR_W_DEF);
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              req_ready;
  logic              stall;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic [7:0]        mem_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, stall, rsp_valid, rsp_rdata, rsp_err,
           mem_re, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, stall, rsp_valid, rsp_rdata, rsp_err,
           mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_byte_master.sv
// Splits 32-bit loads/stores into four little-endian byte beats on an
// 8-bit memory with per-beat ack timeout.
module lsu_byte_master
  import mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input logic               clk,
  input logic               rst,
  lsu_byte_master_if.master bus
);
  localparam int TO_W   = $clog2(ACK_TIMEOUT + 1);
  localparam int BEAT_W = $clog2(BYTES_PER_WORD);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [TO_W-1:0]   to_q, to_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    beat_d  = beat_q;
    to_d    = to_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          beat_d  = '0;
          to_d    = '0;
          state_d = bus.req_write ? WR : RD;
        end
      end
      RD, WR: begin
        if (bus.mem_ack) begin
          if (state_q == RD) rdata_d[{beat_q, 3'b000} +: 8] = bus.mem_rdata;
          beat_d = beat_q + 1'b1;
          to_d   = '0;
          if (beat_q == BEAT_W'(BYTES_PER_WORD - 1)) state_d = DONE;
        end else if (to_q == TO_W'(ACK_TIMEOUT - 1)) begin
          // Bytes never received stay zero from the clear at acceptance.
          err_d   = 1'b1;
          to_d    = '0;
          state_d = DONE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      beat_q  <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      beat_q  <= beat_d;
      to_q    <= to_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.stall     = (state_q != IDLE) || (bus.req_valid && state_q == IDLE);
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.mem_re    = (state_q == RD);
  assign bus.mem_we    = (state_q == WR);
  // Address wraps naturally at the top of memory.
  assign bus.mem_addr  = addr_q + ADDR_W'(beat_q);
  assign bus.mem_wdata = wdata_q[{beat_q, 3'b000} +: 8];
endmodule

// File: tb/tb_lsu_byte_master.sv
// Randomized scoreboard bench for lsu_byte_master with a byte-memory responder.
module tb_lsu_byte_master;
  localparam int AW    = 7;
  localparam int TO    = 15;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lsu_byte_master_if #(.ADDR_W(AW)) bus ();
  lsu_byte_master #(.ADDR_W(AW), .ACK_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  int          vec = 0, mis = 0, cyc = 0;
  logic [7:0]  tb_mem [DEPTH];
  logic [7:0]  ref_mem[DEPTH];
  bit          mem_init = 1'b0;
  int          delay = 0, ack_limit = 4, tb_beat = 0, waitc = 0;
  logic [AW-1:0] cur_addr = '0;
  logic [31:0] cur_wdata = '0;
  logic        cur_write = 1'b0;
  bit          in_flight = 1'b0, held_valid = 1'b0;
  logic [31:0] held_rdata;
  logic        held_err;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory side: bench-owned byte memory, written on acked write beats.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) tb_mem[i] <= 8'(i * 29 + 7);
    end else if (!rst && bus.mem_ack && bus.mem_we) begin
      tb_mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  // Responder and response monitor, both sampling on the falling edge.
  always @(negedge clk) begin
    logic [AW-1:0] ea;
    exp_t e;
    if (rst) begin
      bus.mem_ack = 1'b0;
      bus.mem_rdata = '0;
      waitc = 0;
    end else begin
      if (bus.mem_re || bus.mem_we) begin
        ea = cur_addr + AW'(tb_beat);
        chk("strobe_excl", 32'(bus.mem_re & bus.mem_we), 32'd0);
        chk("strobe_kind", 32'(bus.mem_we), 32'(cur_write));
        chk("mem_addr", 32'(bus.mem_addr), 32'(ea));
        if (bus.mem_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(cur_wdata[8*tb_beat +: 8]));
        if (tb_beat < ack_limit && waitc >= delay) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = tb_mem[ea];
          waitc = 0;
          tb_beat++;
        end else begin
          bus.mem_ack = 1'b0;
          bus.mem_rdata = 8'($urandom);
          waitc++;
        end
      end else begin
        // Stray acks while no beat is open must be ignored.
        bus.mem_ack = 1'($urandom_range(0, 1));
        bus.mem_rdata = 8'($urandom);
        waitc = 0;
      end

      if (bus.rsp_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("done_strobes", 32'({bus.mem_re, bus.mem_we}), 32'd0);
          in_flight = 1'b0;
          held_valid = 1'b1;
          held_rdata = e.rdata;
          held_err = e.err;
        end
      end else if (in_flight) begin
        chk("busy_ready", 32'(bus.req_ready), 32'd0);
        chk("busy_stall", 32'(bus.stall), 32'd1);
      end else if (held_valid) begin
        chk("held_rdata", bus.rsp_rdata, held_rdata);
        chk("held_err", 32'(bus.rsp_err), 32'(held_err));
      end
    end
  end

  // Issue one request; model: nacks beats complete, the rest time out.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [31:0] wd,
                       input int d, input int nacks);
    exp_t e;
    int t = 0;
    logic [AW-1:0] ba;
    @(negedge clk);
    while (!bus.req_ready) begin
      @(negedge clk);
      t++;
      if (t > 500) begin
        chk("idle_timeout", 32'd0, 32'd1);
        return;
      end
    end
    e.rdata = '0;
    for (int k = 0; k < nacks; k++) begin
      ba = a + AW'(k);
      if (wr) ref_mem[ba] = wd[8*k +: 8];
      else    e.rdata[8*k +: 8] = ref_mem[ba];
    end
    e.err = (nacks < 4);
    e.lat = 1 + nacks * (d + 1) + ((nacks < 4) ? TO : 0);
    e.acc = cyc;
    sbq.push_back(e);
    delay = d; ack_limit = nacks; tb_beat = 0;
    cur_addr = a; cur_wdata = wd; cur_write = wr;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1;
    in_flight = 1'b1;
    // Keep presenting junk while busy; it must not be captured.
    bus.req_write = 1'($urandom); bus.req_addr = AW'($urandom); bus.req_wdata = $urandom;
    repeat (2) @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sbq.size() != 0 || in_flight) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] old2, old3;
    int n;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(i * 29 + 7);
    mem_init = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_strobes", 32'({bus.mem_re, bus.mem_we}), 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    rst = 1'b0;

    issue(1'b1, 7'h10, 32'hA1B2C3D4, 0, 4);
    drain();
    chk("st10_b0", 32'(tb_mem[7'h10]), 32'hD4);
    chk("st10_b1", 32'(tb_mem[7'h11]), 32'hC3);
    chk("st10_b2", 32'(tb_mem[7'h12]), 32'hB2);
    chk("st10_b3", 32'(tb_mem[7'h13]), 32'hA1);
    issue(1'b0, 7'h10, 32'h0, 0, 4);
    drain();
    chk("ld10_value", held_rdata, 32'hA1B2C3D4);

    issue(1'b1, 7'h7E, 32'h11223344, 0, 4);
    drain();
    chk("wrap_7e", 32'(tb_mem[7'h7E]), 32'h44);
    chk("wrap_7f", 32'(tb_mem[7'h7F]), 32'h33);
    chk("wrap_00", 32'(tb_mem[7'h00]), 32'h22);
    chk("wrap_01", 32'(tb_mem[7'h01]), 32'h11);
    issue(1'b0, 7'h7E, 32'h0, 3, 4);
    drain();

    issue(1'b1, 7'h20, 32'h0000005A, 0, 4);
    drain();
    issue(1'b0, 7'h20, 32'h0, 0, 1);
    drain();
    chk("timeout_rdata", held_rdata, 32'h0000005A);

    // Reset while beat 2 of a store is open: first two bytes stay written.
    old2 = ref_mem[7'h42]; old3 = ref_mem[7'h43];
    issue(1'b1, 7'h40, 32'hCAFEF00D, 0, 4);
    while (tb_beat < 2) @(posedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    chk("mid_rst_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_strobes", 32'({bus.mem_re, bus.mem_we}), 32'd0);
    chk("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("mid_rst_stall", 32'(bus.stall), 32'd0);
    sbq.delete();
    in_flight = 1'b0; held_valid = 1'b0;
    ref_mem[7'h42] = old2; ref_mem[7'h43] = old3;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    issue(1'b0, 7'h40, 32'h0, 0, 4);
    drain();
    chk("post_rst_load", held_rdata, {old3, old2, 16'hF00D});

    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 5);
      if (n > 3 && $urandom_range(0, 3) != 0) n = 4;
      else if (n > 4) n = 4;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(1'($urandom), AW'($urandom), $urandom, $urandom_range(0, 3), n);
    end
    drain();
    for (int i = 0; i < DEPTH; i++) chk("mem_final", 32'(tb_mem[i]), 32'(ref_mem[i]));

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
